// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per clock; signed mode under SEQ_DIVIDER_SIGNED_EN
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic             idle,
  output logic             finish,
  output logic             dbz,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_p, r_n, r_d, r_q, r_r;
  logic             r_neg_n, r_neg_q, r_dbz;
  logic             w_neg_n, w_neg_d, w_ge;
  logic [WIDTH-1:0] w_n_mag, w_d_mag, w_q_fix, w_r_fix;
  logic [WIDTH:0]   w_p_sh;
`ifndef SEQ_DIVIDER_SIGNED_EN
  logic w_unused_sm;
  assign w_unused_sm = signed_mode;
`endif
  // operand conditioning: sign flags and magnitudes captured on start
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    w_neg_n = signed_mode & N[WIDTH-1];
    w_neg_d = signed_mode & D[WIDTH-1];
`else
    w_neg_n = 1'b0;
    w_neg_d = 1'b0;
`endif
    w_n_mag = w_neg_n ? -N : N;
    w_d_mag = w_neg_d ? -D : D;
    w_p_sh  = {r_p, r_n[WIDTH-1]};
    w_ge    = w_p_sh >= {1'b0, r_d};
    w_q_fix = r_neg_q ? -r_n : r_n;
    w_r_fix = r_neg_n ? -r_p : r_p;
  end
  // next-state: zero divisor skips straight to DONE
  always_comb begin
    w_next = r_state == IDLE ? (start ? (D == '0 ? DONE : ITER) : IDLE) :
             r_state == ITER ? (r_cnt == '0 ? FIX : ITER) :
             r_state == FIX  ? DONE : IDLE;
  end
  // state register
  always_ff @(posedge CLK or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  // datapath: capture, one restoring step per ITER cycle, results written on entry to DONE
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_n     <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_neg_n <= 1'b0;
      r_neg_q <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_p     <= '0;
          r_n     <= w_n_mag;
          r_d     <= w_d_mag;
          r_cnt   <= CNT_W'(WIDTH - 1);
          r_neg_n <= w_neg_n;
          r_neg_q <= w_neg_n ^ w_neg_d;
          if (D == '0) begin
            r_q   <= '1;
            r_r   <= N;
            r_dbz <= 1'b1;
          end
        end
        ITER: begin
          r_p   <= w_ge ? WIDTH'(w_p_sh - {1'b0, r_d}) : w_p_sh[WIDTH-1:0];
          r_n   <= {r_n[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          r_q   <= w_q_fix;
          r_r   <= w_r_fix;
          r_dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  assign idle   = r_state == IDLE;
  assign finish = r_state == DONE;
  assign dbz    = r_dbz;
  assign Q      = r_q;
  assign R      = r_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider at WIDTH=8 and WIDTH=16
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sm_i = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  n8 = '0, d8 = '0, q8, r8;
  logic [15:0] n16 = '0, d16 = '0, q16, r16;
  logic        idle8, fin8, dbz8, idle16, fin16, dbz16;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) u_div8 (
    .CLK(clk), .reset(rst_n), .start(start8), .signed_mode(sm_i), .N(n8), .D(d8),
    .idle(idle8), .finish(fin8), .dbz(dbz8), .Q(q8), .R(r8));

  seq_divider #(.WIDTH(16)) u_div16 (
    .CLK(clk), .reset(rst_n), .start(start16), .signed_mode(sm_i), .N(n16), .D(d16),
    .idle(idle16), .finish(fin16), .dbz(dbz16), .Q(q16), .R(r16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic div(input bit wide, input logic [15:0] n, input logic [15:0] d, input bit sm,
                     input int lat, input logic [15:0] eq, input logic [15:0] er,
                     input logic edbz, input string tag);
    int c;
    @(negedge clk);
    if (wide) begin n16 = n; d16 = d; start16 = 1'b1; end
    else begin n8 = n[7:0]; d8 = d[7:0]; start8 = 1'b1; end
    sm_i = sm;
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    c = 1;
    while (!(wide ? fin16 : fin8) && c < 40) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_lat"}, c, lat);
    check({tag, "_q"}, wide ? q16 : {8'h0, q8}, eq);
    check({tag, "_r"}, wide ? r16 : {8'h0, r8}, er);
    check({tag, "_dbz"}, wide ? dbz16 : dbz8, edbz);
    @(negedge clk);
    check({tag, "_pulse"}, wide ? fin16 : fin8, 1'b0);
    check({tag, "_idle"}, wide ? idle16 : idle8, 1'b1);
  endtask

  initial begin
    int  c;
    bit  saw_fin;
    repeat (2) @(negedge clk);
    check("rst_idle", idle8, 1'b1);
    check("rst_fin", fin8, 1'b0);
    check("rst_q", q8, 8'h00);
    check("rst_r", r8, 8'h00);
    check("rst_dbz", dbz8, 1'b0);
    rst_n = 1'b1;

    div(0, 200, 7, 0, 10, 28, 4, 0, "u200_7");
    div(0, 5, 0, 0, 1, 16'h00FF, 16'h0005, 1, "dbz5");
    div(0, 9, 3, 0, 10, 3, 0, 0, "u9_3");
`ifdef SEQ_DIVIDER_SIGNED_EN
    div(0, 16'h00F9, 2, 1, 10, 16'h00FD, 16'h00FF, 0, "sm7_2");
    div(0, 16'h0080, 16'h00FF, 1, 10, 16'h0080, 16'h0000, 0, "sovf");
    div(0, 100, 16'h00F9, 1, 10, 16'h00F2, 16'h0002, 0, "s100_m7");
`else
    div(0, 16'h00F9, 2, 1, 10, 16'h007C, 16'h0001, 0, "sm7_2");
    div(0, 16'h0080, 16'h00FF, 1, 10, 16'h0000, 16'h0080, 0, "sovf");
    div(0, 100, 16'h00F9, 1, 10, 16'h0000, 16'h0064, 0, "s100_m7");
`endif
    div(0, 16'h00F9, 0, 1, 1, 16'h00FF, 16'h00F9, 1, "sdbz");
    repeat (3) @(negedge clk);
    check("hold_q", q8, 8'hFF);
    check("hold_r", r8, 8'hF9);
    check("hold_dbz", dbz8, 1'b1);

    n8 = 100; d8 = 9; sm_i = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    c = 1;
    repeat (2) begin @(negedge clk); c++; end
    n8 = 1; d8 = 1; sm_i = 1'b1; start8 = 1'b1;
    @(negedge clk);
    c++;
    start8 = 1'b0;
    while (!fin8 && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("ign_lat", c, 10);
    check("ign_q", q8, 8'd11);
    check("ign_r", r8, 8'd1);
    @(negedge clk);

    n8 = 77; d8 = 4; sm_i = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_idle", idle8, 1'b1);
    check("mid_fin", fin8, 1'b0);
    check("mid_q", q8, 8'h00);
    check("mid_r", r8, 8'h00);
    check("mid_dbz", dbz8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_fin = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (fin8 || !idle8) saw_fin = 1'b1;
    end
    check("mid_nofin", saw_fin, 1'b0);
    div(0, 50, 5, 0, 10, 10, 0, 0, "u50_5");

    div(1, 16'hFFFF, 255, 0, 18, 257, 0, 0, "w65535_255");
    div(1, 1000, 3000, 0, 18, 0, 1000, 0, "w1000_3000");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider: computes quotient Q and remainder R of N / D for WIDTH-bit operands using a restoring shift-subtract datapath, one quotient bit per clock. Successor to the fixed 8-bit divider; adds width generalisation, an optional signed mode and divide-by-zero reporting. Sits behind a start/idle/finish handshake and is driven by a higher-level controller or testbench.

## Interface

- WIDTH, 8: operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

- CLK  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- N  input  WIDTH  dividend; sampled with start.
- D  input  WIDTH  divisor; sampled with start.
- idle  output  1  high while in IDLE (ready to accept start).
- finish  output  1  one-cycle pulse; R, Q, dbz are valid from this cycle.
- dbz  output  1  divide-by-zero flag for the last completed operation.
- Q  output  WIDTH  quotient (registered).
- R  output  WIDTH  remainder (registered).

## Operation

- States: IDLE, ITER, FIX, DONE.
- IDLE: idle=1. On edge with start=1: latch signed_mode, |N|, |D| (magnitudes only when signed), sign of N, sign of N xor sign of D; clear partial remainder; counter = WIDTH-1. If D==0 go to DONE, else ITER.
- ITER: one restoring step per cycle: P = {P, next dividend MSB}; if P >= |D| then P -= |D|, quotient bit = 1, else 0. Counter decrements; after the step with counter==0 go to FIX. Partial remainder is WIDTH+1 bits internally.
- FIX: sign correction. Unsigned: none. Signed: Q negated if operand signs differ; R takes sign of N (negated if N negative). Result written to Q/R registers; go to DONE.
- DONE: finish=1 for exactly one cycle; go to IDLE.
- Divide by zero: dbz=1, Q = all ones, R = N (raw input bits, both modes). Non-zero divisor: dbz=0.
- Signed overflow (most-negative / -1): Q = most-negative value (wraps), R = 0, dbz=0.
- start outside IDLE is ignored; N, D, signed_mode changes during an operation have no effect.
- Q, R, dbz hold their values until overwritten by the next completed operation.
- Reset (any time, including mid-operation): state=IDLE, idle=1, finish=0, dbz=0, Q=0, R=0; in-flight operation discarded.

## Timing

- Start sampled at edge k (state IDLE).
- D!=0: ITER during cycles k+1..k+WIDTH, FIX at k+WIDTH+1, DONE (finish=1, results valid) at cycle k+WIDTH+2; IDLE again at k+WIDTH+3. Latency start-edge to finish: WIDTH+2 cycles.
- D==0: DONE in cycle k+1 (finish=1, dbz=1); IDLE at k+2.
- idle drops the cycle after start is accepted; a new start may be accepted on the first IDLE edge, giving a throughput of one division per WIDTH+3 cycles.
- Q/R/dbz change only on the edge entering DONE.

## Configuration

- SEQ_DIVIDER_SIGNED_EN defined: signed_mode honoured, magnitude/sign-fix logic present in IDLE and FIX.
- Not defined: signed_mode port kept but ignored; all operations unsigned; FIX becomes a plain result-write cycle (latency unchanged).

## Test plan

- WIDTH=8, unsigned, N=200, D=7 -> finish at start+10 cycles, Q=28, R=4, dbz=0.
- WIDTH=8, N=5, D=0 -> finish at start+1, Q=0xFF, R=0x05, dbz=1; next division N=9, D=3 -> Q=3, R=0, dbz=0.
- WIDTH=8, signed (macro on), N=0xF9 (-7), D=2 -> Q=0xFD (-3), R=0xFF (-1); N=0x80, D=0xFF -> Q=0x80, R=0x00; same vectors with macro off -> Q=0x7C, R=0x01 and Q=0x00, R=0x80.
- WIDTH=8, N=100, D=9 running; pulse start with N=1, D=1 in ITER -> ignored, result Q=11, R=1.
- Assert reset low in cycle 4 of an operation -> idle=1, finish=0, Q=0, R=0, dbz=0 immediately; no finish pulse follows; next start N=50, D=5 -> Q=10, R=0.
- WIDTH=16, N=65535, D=255 -> finish at start+18, Q=257, R=0; N=1000, D=3000 -> Q=0, R=1000.
